// File: rtl/snoopy_axis_mover_pkg.sv
// ----------------------------------------------------------------------------
// snoopy_pkg
// Shared definitions for the Snoopy single-axis motion controller.
//   - FSM state encodings (2-bit, kept as plain constants so older blocks that
//     compare raw state codes keep working)
//   - direction encodings
//   - speed-ramp operation codes driven by the axis FSM into the ramp block
// ----------------------------------------------------------------------------
package snoopy_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MOVE  = 2'd1;
    localparam logic [1:0] S_BRAKE = 2'd2;

    localparam logic DIR_NEG = 1'b0;
    localparam logic DIR_POS = 1'b1;

    // What the speed ramp does on a move tick.
    //   RAMP_HOLD  : keep speed and hold counter
    //   RAMP_START : restart at speed 1 and count this tick as a held tick
    //   RAMP_COUNT : count a held tick, accelerate when the hold period ends
    //   RAMP_BRAKE : drop one speed step, restart the hold period
    //   RAMP_CLEAR : stop dead (wall hit)
    typedef enum logic [2:0] {
        RAMP_HOLD  = 3'd0,
        RAMP_START = 3'd1,
        RAMP_COUNT = 3'd2,
        RAMP_BRAKE = 3'd3,
        RAMP_CLEAR = 3'd4
    } ramp_op_t;

endpackage

// File: rtl/snoopy_axis_mover_speed_ramp.sv
// ----------------------------------------------------------------------------
// snoopy_speed_ramp
// Speed register plus hold counter for one axis. The axis FSM selects an
// operation each move tick; the ramp applies it only when en is high.
// Acceleration: after ACCEL_TICKS held ticks at one speed, speed steps up by
// one, saturating at MAX_SPEED.
// Ports:
//   clock    in   1      system clock
//   reset    in   1      asynchronous active-high reset (speed=0, count=0)
//   en       in   1      move tick; all updates gated by it
//   op       in   3      ramp operation (ramp_op_t)
//   speed    out  SPD_W  current speed in pixels per tick
// ----------------------------------------------------------------------------
module snoopy_speed_ramp
    import snoopy_pkg::*;
#(
    parameter int MAX_SPEED   = 3,
    parameter int ACCEL_TICKS = 4,
    parameter int SPD_W       = $clog2(MAX_SPEED + 1),
    parameter int CNT_W       = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  ramp_op_t         op,
    output logic [SPD_W-1:0] speed
);

    localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(MAX_SPEED);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_TICKS - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic [SPD_W-1:0] base_spd;
    logic [CNT_W-1:0] base_cnt;
    logic [SPD_W-1:0] spd_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Saturating speed increment: never exceeds MAX_SPEED.
    function automatic logic [SPD_W-1:0] sat_inc(input logic [SPD_W-1:0] s);
        if (s >= SPD_MAX) begin
            return SPD_MAX;
        end
        return s + SPD_W'(1);
    endfunction

    always_comb begin
        base_spd = speed;
        base_cnt = hold_cnt;
        spd_nxt  = speed;
        cnt_nxt  = hold_cnt;

        // A start behaves like a count applied to a fresh (speed 1, count 0)
        // state, so the entry tick already counts towards acceleration.
        if (op == RAMP_START) begin
            base_spd = SPD_W'(1);
            base_cnt = '0;
        end

        case (op)
            RAMP_START, RAMP_COUNT: begin
                spd_nxt = base_spd;
                if (base_cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    spd_nxt = sat_inc(base_spd);
                end else begin
                    cnt_nxt = base_cnt + CNT_W'(1);
                end
            end
            RAMP_BRAKE: begin
                spd_nxt = (speed != '0) ? speed - SPD_W'(1) : '0;
                cnt_nxt = '0;
            end
            RAMP_CLEAR: begin
                spd_nxt = '0;
                cnt_nxt = '0;
            end
            default: begin
                spd_nxt = speed;
                cnt_nxt = hold_cnt;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            speed    <= '0;
            hold_cnt <= '0;
        end else if (en) begin
            speed    <= spd_nxt;
            hold_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/snoopy_axis_mover.sv
// ----------------------------------------------------------------------------
// snoopy_axis_mover
// Single-axis motion controller for Snoopy (one instance per axis). Held
// direction buttons become a position that ramps up in speed, brakes down
// when released, and stops dead against the MIN_POS/MAX_POS walls. All motion
// happens on move_tick (frame strobe); outputs change one clock after the
// tick edge.
// Ports:
//   clock      in   1      system clock
//   reset      in   1      asynchronous active-high reset
//   move_tick  in   1      1-cycle frame strobe gating every update
//   input_neg  in   1      button towards MIN_POS (level)
//   input_pos  in   1      button towards MAX_POS (level)
//   pos        out  POS_W  current position
//   speed      out  SPD_W  current speed (pixels per tick)
//   dir        out  1      0 = towards MIN, 1 = towards MAX (valid when speed!=0)
//   at_min     out  1      pos == MIN_POS
//   at_max     out  1      pos == MAX_POS
// ----------------------------------------------------------------------------
module snoopy_axis_mover
    import snoopy_pkg::*;
#(
    parameter int POS_W       = 8,
    parameter int MIN_POS     = 0,
    parameter int MAX_POS     = 160,
    parameter int RESET_POS   = 15,
    parameter int MAX_SPEED   = 3,
    parameter int ACCEL_TICKS = 4,
    localparam int SPD_W      = $clog2(MAX_SPEED + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             move_tick,
    input  logic             input_neg,
    input  logic             input_pos,
    output logic [POS_W-1:0] pos,
    output logic [SPD_W-1:0] speed,
    output logic             dir,
    output logic             at_min,
    output logic             at_max
);

    localparam int EXT_W = POS_W + 2;
    localparam logic signed [EXT_W-1:0] MIN_S = EXT_W'(MIN_POS);
    localparam logic signed [EXT_W-1:0] MAX_S = EXT_W'(MAX_POS);

    // Parameter sanity, caught at elaboration.
    if (RESET_POS < MIN_POS || RESET_POS > MAX_POS) begin : g_bad_reset_pos
        $error("snoopy_axis_mover: RESET_POS outside [MIN_POS,MAX_POS]");
    end
    if (MIN_POS < 0 || MIN_POS > MAX_POS || MAX_POS >= (2 ** POS_W)) begin : g_bad_range
        $error("snoopy_axis_mover: illegal MIN_POS/MAX_POS for POS_W");
    end
    if (MAX_SPEED < 1 || ACCEL_TICKS < 1 || SPD_W > EXT_W) begin : g_bad_speed
        $error("snoopy_axis_mover: illegal MAX_SPEED/ACCEL_TICKS");
    end

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic                    dir_nxt;
    logic                    req_neg;
    logic                    req_pos;
    logic                    req_match;
    logic                    moving;
    logic                    wall;
    logic [SPD_W-1:0]        step_amt;
    logic signed [EXT_W-1:0] cur_s;
    logic signed [EXT_W-1:0] step_s;
    logic signed [EXT_W-1:0] next_s;
    ramp_op_t                ramp_op;

    // Wall clamp: out-of-range positions snap to the nearest wall.
    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [EXT_W-1:0] v);
        if (v > MAX_S) begin
            return POS_W'(MAX_POS);
        end
        if (v < MIN_S) begin
            return POS_W'(MIN_POS);
        end
        return v[POS_W-1:0];
    endfunction

    assign req_neg   = input_neg & ~input_pos;
    assign req_pos   = input_pos & ~input_neg;
    assign req_match = (dir == DIR_POS) ? req_pos : req_neg;

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        ramp_op   = RAMP_HOLD;
        step_amt  = '0;
        moving    = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_neg || req_pos) begin
                    state_nxt = S_MOVE;
                    dir_nxt   = req_pos ? DIR_POS : DIR_NEG;
                    ramp_op   = RAMP_START;
                    step_amt  = SPD_W'(1);
                    moving    = 1'b1;
                end
            end
            S_MOVE, S_BRAKE: begin
                moving = 1'b1;
                if (req_match) begin
                    // Keep going (or resume from braking) at the current speed.
                    state_nxt = S_MOVE;
                    ramp_op   = RAMP_COUNT;
                    step_amt  = speed;
                end else begin
                    // Braking steps by the already-reduced speed; reaching
                    // zero returns straight to idle.
                    ramp_op   = RAMP_BRAKE;
                    step_amt  = (speed != '0) ? speed - SPD_W'(1) : '0;
                    state_nxt = (speed <= SPD_W'(1)) ? S_IDLE : S_BRAKE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                ramp_op   = RAMP_CLEAR;
            end
        endcase

        // Step in POS_W+2 signed bits so neither wall can wrap around.
        cur_s  = $signed({2'b00, pos});
        step_s = $signed({{(EXT_W - SPD_W){1'b0}}, step_amt});
        next_s = (dir_nxt == DIR_POS) ? cur_s + step_s : cur_s - step_s;
        wall   = moving && ((next_s > MAX_S) || (next_s < MIN_S));

        // A wall hit stops dead on the same tick, no brake phase.
        if (wall) begin
            state_nxt = S_IDLE;
            ramp_op   = RAMP_CLEAR;
        end
    end

    snoopy_speed_ramp #(
        .MAX_SPEED   (MAX_SPEED),
        .ACCEL_TICKS (ACCEL_TICKS)
    ) u_ramp (
        .clock (clock),
        .reset (reset),
        .en    (move_tick),
        .op    (ramp_op),
        .speed (speed)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            dir   <= DIR_NEG;
            pos   <= POS_W'(RESET_POS);
        end else if (move_tick) begin
            state <= state_nxt;
            dir   <= dir_nxt;
            if (moving) begin
                pos <= clamp_pos(next_s);
            end
        end
    end

    assign at_min = (pos == POS_W'(MIN_POS));
    assign at_max = (pos == POS_W'(MAX_POS));

endmodule
